// File: rtl/keypad_event_queue.sv
// rtl/keypad_event_queue.sv - keypad press/release event tracker feeding a popped event FIFO
// Optional auto-repeat of held keys is compiled in with KEYPAD_AUTOREPEAT_EN.
module keypad_event_queue #(
    parameter int          DEPTH_LOG2    = 4,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [5:0]            keyCode,
    input  logic                  keyReady,
    output logic [7:0]            evData,
    output logic                  evValid,
    input  logic                  evPop,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovfClear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t                state;
    logic                  kr_q;
    logic [5:0]            kc_q;
    logic [5:0]            held;
    logic [5:0]            pending;
    logic                  kc_valid;
    logic                  push;
    logic [7:0]            push_data;
    logic                  rep_fire;

    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2:0]   wr_next;
    logic [DEPTH_LOG2:0]   rd_next;
    logic [7:0]            mem [DEPTH];
    logic                  empty;
    logic                  full;
    logic                  do_pop;
    logic                  accept;

    assign kc_valid = (kc_q[2:0] != 3'd7) && (kc_q[5:3] != 3'd7);

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [23:0] hold_cnt;
    logic [23:0] hold_target;
    logic        enter_held;

    assign enter_held = ((state == IDLE) && kr_q && kc_valid) || (state == SWITCH);
    assign rep_fire   = (state == HELD) && kr_q && (kc_q == held) &&
                        (hold_cnt == hold_target - 24'd1);

    // Counter restarts on every entry to HELD; after the first repeat the period takes over.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_cnt    <= 24'd0;
            hold_target <= REPEAT_DELAY;
        end else if (enter_held) begin
            hold_cnt    <= 24'd0;
            hold_target <= REPEAT_DELAY;
        end else if (rep_fire) begin
            hold_cnt    <= 24'd0;
            hold_target <= REPEAT_PERIOD;
        end else if (state == HELD) begin
            hold_cnt    <= hold_cnt + 24'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
    wire unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        case (state)
            IDLE: begin
                if (kr_q && kc_valid) begin
                    push      = 1'b1;
                    push_data = {2'b10, kc_q};
                end
            end
            HELD: begin
                if (!kr_q || (kc_q != held)) begin
                    push      = 1'b1;
                    push_data = {2'b00, held};
                end else if (rep_fire) begin
                    push      = 1'b1;
                    push_data = {2'b11, held};
                end
            end
            SWITCH: begin
                push      = 1'b1;
                push_data = {2'b10, pending};
            end
            default: ;
        endcase
    end

    // SWITCH always returns to HELD; a dropped keyReady then yields the release one cycle later.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            held    <= 6'h3F;
            pending <= 6'h3F;
            kr_q    <= 1'b0;
            kc_q    <= 6'h3F;
        end else begin
            kr_q <= keyReady;
            kc_q <= keyCode;
            case (state)
                IDLE: begin
                    if (kr_q && kc_valid) begin
                        held  <= kc_q;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (!kr_q) begin
                        state <= IDLE;
                    end else if (kc_q != held) begin
                        pending <= kc_q;
                        state   <= SWITCH;
                    end
                end
                SWITCH: begin
                    held  <= pending;
                    state <= HELD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                     (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign do_pop  = evPop && !empty;
    assign accept  = push && (!full || do_pop);
    assign rd_next = rd_ptr + (DEPTH_LOG2+1)'(do_pop);
    assign wr_next = wr_ptr + (DEPTH_LOG2+1)'(accept);
    assign count   = wr_ptr - rd_ptr;
    assign evValid = !empty;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    // Head register bypasses the array when the incoming event becomes the new head.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            evData   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (accept && (rd_next == wr_ptr)) begin
                evData <= push_data;
            end else begin
                evData <= mem[rd_next[DEPTH_LOG2-1:0]];
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end else if (ovfClear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_event_queue.sv
// tb/tb_keypad_event_queue.sv - randomized and directed bench for keypad_event_queue with a queue-based event model
module tb_keypad_event_queue;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [23:0] RD = 24'd20;
    localparam logic [23:0] RP = 24'd5;
`else
    localparam logic [23:0] RD = 24'd5_000_000;
    localparam logic [23:0] RP = 24'd1_000_000;
`endif

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [5:0]          keyCode = 6'h00;
    logic                keyReady = 1'b0;
    logic [7:0]          evData;
    logic                evValid;
    logic                evPop = 1'b0;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                ovfClear = 1'b0;

    keypad_event_queue #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .keyCode  (keyCode),
        .keyReady (keyReady),
        .evData   (evData),
        .evValid  (evValid),
        .evPop    (evPop),
        .count    (count),
        .overflow (overflow),
        .ovfClear (ovfClear)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;

    int         q[$];
    bit         m_ovf = 1'b0;
    int         m_key = -1;
    int         m_pend = -1;
    int         m_age = 0;
    bit         m_rst = 1'b1;
    bit         p_ready = 1'b0;
    logic [5:0] p_code = 6'h3F;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Event generation from the key-level history seen one registration stage late.
    task automatic model_step(input bit r, input bit rdy, input logic [5:0] code,
                              input bit pop, input bit clr);
        int ev;
        bit set_ovf;
        m_rst = !r;
        if (!r) begin
            q.delete();
            m_ovf   = 1'b0;
            m_key   = -1;
            m_pend  = -1;
            m_age   = 0;
            p_ready = 1'b0;
            p_code  = 6'h3F;
            return;
        end
        ev = -1;
        if (m_pend >= 0) begin
            ev     = 'h80 | m_pend;
            m_key  = m_pend;
            m_pend = -1;
            m_age  = 0;
        end else if (m_key < 0) begin
            if (p_ready && p_code[2:0] != 3'd7 && p_code[5:3] != 3'd7) begin
                ev    = 'h80 | int'(p_code);
                m_key = int'(p_code);
                m_age = 0;
            end
        end else if (!p_ready) begin
            ev    = m_key;
            m_key = -1;
        end else if (int'(p_code) != m_key) begin
            ev     = m_key;
            m_pend = int'(p_code);
        end else begin
            m_age++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_age == int'(RD) || (m_age > int'(RD) && (m_age - int'(RD)) % int'(RP) == 0))
                ev = 'hC0 | m_key;
`endif
        end
        if (pop && q.size() > 0) void'(q.pop_front());
        set_ovf = 1'b0;
        if (ev >= 0) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else set_ovf = 1'b1;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        p_ready = rdy;
        p_code  = code;
    endtask

    task automatic compare_all();
        check("ev_valid", 32'(evValid), 32'(q.size() != 0));
        check("count", 32'(count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) check("ev_data", 32'(evData), 32'(q[0]));
        if (m_rst) check("rst_ev_data", 32'(evData), 32'h00);
    endtask

    task automatic step(input bit r, input bit rdy, input logic [5:0] code,
                        input bit pop, input bit clr);
        @(negedge clk);
        rstn     = r;
        keyReady = rdy;
        keyCode  = code;
        evPop    = pop;
        ovfClear = clr;
        model_step(r, rdy, code, pop, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    endtask

    initial begin : main
        logic [7:0] exp3 [4];
        logic [7:0] e [16];
        logic [5:0] c;
        logic [5:0] codes [6];
        bit         rdy;
        bit         r;

        do_reset();
        check("rst_count_const", 32'(count), 32'd0);
        check("rst_valid_const", 32'(evValid), 32'd0);

        // single press/release and two-cycle latency
        step(1, 1, 6'h0A, 0, 0);
        check("lat_cycle1", 32'(evValid), 32'd0);
        step(1, 1, 6'h0A, 0, 0);
        check("lat_cycle2", 32'(evValid), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 1, 6'h0A, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 6'h0A, 0, 0);
        check("t1_count", 32'(count), 32'd2);
        check("t1_head", 32'(evData), 32'h8A);
        step(1, 0, 6'h0A, 1, 0);
        check("t1_second", 32'(evData), 32'h0A);
        step(1, 0, 6'h0A, 1, 0);

        // direct switch between keys
        do_reset();
        exp3 = '{8'h8A, 8'h0A, 8'h93, 8'h13};
        for (int i = 0; i < 4; i++) step(1, 1, 6'h0A, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 6'h13, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 6'h13, 0, 0);
        check("sw_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("sw_order", 32'(evData), 32'(exp3[i]));
            step(1, 0, 6'h13, 1, 0);
        end
        check("sw_empty", 32'(evValid), 32'd0);

        // invalid column ignored
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 6'h07, 0, 0);
        step(1, 0, 6'h07, 0, 0);
        step(1, 0, 6'h07, 0, 0);
        check("inv_count", 32'(count), 32'd0);

        // overflow with 18 events
        do_reset();
        for (int k = 0; k < 9; k++) begin
            c = {3'(k % 5), 3'((k * 2 + 1) % 5)};
            if (k < 8) begin
                e[2*k]   = {2'b10, c};
                e[2*k+1] = {2'b00, c};
            end
            for (int i = 0; i < 3; i++) step(1, 1, c, 0, 0);
            for (int i = 0; i < 3; i++) step(1, 0, c, 0, 0);
        end
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(evData), 32'(e[0]));
        step(1, 0, 6'h24, 0, 1);
        check("ovf_clear", 32'(overflow), 32'd0);

        // push and pop together while full, then drain across the wrap
        step(1, 1, 6'h24, 0, 0);
        step(1, 1, 6'h24, 1, 0);
        check("full_pp_count", 32'(count), 32'd16);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("drain_head", 32'(evData), 32'(e[1]));
        for (int j = 1; j <= 16; j++) begin
            step(1, 1, 6'h24, 1, 0);
            if (j <= 14) check("drain", 32'(evData), 32'(e[j+1]));
            else if (j == 15) check("drain_last", 32'(evData), 32'hA4);
            else check("drain_empty", 32'(evValid), 32'd0);
        end
        step(1, 0, 6'h24, 0, 0);
        step(1, 0, 6'h24, 1, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 1, 6'h21, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 6'h21, 0, 0);
        check("rep_count", 32'(count), 32'd6);
        check("rep_press", 32'(evData), 32'hA1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 6'h21, 1, 0);
            check("rep_event", 32'(evData), 32'hE1);
        end
        step(1, 0, 6'h21, 1, 0);
        check("rep_release", 32'(evData), 32'h21);
`endif

        // randomized levels, codes, pops, clears and occasional resets
        do_reset();
        codes = '{6'h00, 6'h0A, 6'h13, 6'h21, 6'h24, 6'h3C};
        rdy = 1'b0;
        c   = 6'h0A;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 25) rdy = ($urandom_range(99) < 55);
            if ($urandom_range(99) < 15) c = codes[$urandom_range(5)];
            if ($urandom_range(99) < 2) c = 6'($urandom);
            r = ($urandom_range(999) >= 3);
            step(r, rdy, c, ($urandom_range(99) < ((i / 500) % 2 == 0 ? 20 : 60)),
                 ($urandom_range(99) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
